// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges the alu1/alu2/mult/ld results onto two register-file
// write ports and two ROB completion ports. Each source owns a one-entry
// holding buffer; a rotating-priority pointer resolves contention and
// stall_out holds the EX/WB register while more than two entries are pending.
// Build option: define WB_LD_PRIORITY_EN to give an occupied ld entry port 0
// unconditionally, with the rotation pointer tracking only non-ld grants.
module wb_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu1_vld,
  input  logic              alu1_wrt,
  input  logic [DATA_W-1:0] alu1_data,
  input  logic [TAG_W-1:0]  alu1_phy,
  input  logic [TAG_W-1:0]  alu1_idx,
  input  logic              alu2_vld,
  input  logic              alu2_wrt,
  input  logic [DATA_W-1:0] alu2_data,
  input  logic [TAG_W-1:0]  alu2_phy,
  input  logic [TAG_W-1:0]  alu2_idx,
  input  logic              mult_vld,
  input  logic              mult_wrt,
  input  logic [DATA_W-1:0] mult_data,
  input  logic [TAG_W-1:0]  mult_phy,
  input  logic [TAG_W-1:0]  mult_idx,
  input  logic              ld_vld,
  input  logic              ld_wrt,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [TAG_W-1:0]  ld_phy,
  input  logic [TAG_W-1:0]  ld_idx,
  output logic              wp_en_0,
  output logic [TAG_W-1:0]  wp_addr_0,
  output logic [DATA_W-1:0] wp_data_0,
  output logic              cmpl_vld_0,
  output logic [TAG_W-1:0]  cmpl_idx_0,
  output logic              wp_en_1,
  output logic [TAG_W-1:0]  wp_addr_1,
  output logic [DATA_W-1:0] wp_data_1,
  output logic              cmpl_vld_1,
  output logic [TAG_W-1:0]  cmpl_idx_1,
  output logic              stall_out
);

  localparam int NSRC = 4;
`ifdef WB_LD_PRIORITY_EN
  localparam logic [1:0] LD = 2'd3;
`endif

  // Source order alu1=0, alu2=1, mult=2, ld=3 matches the scan order
  logic [NSRC-1:0]   in_vld, in_wrt;
  logic [DATA_W-1:0] in_data [NSRC];
  logic [TAG_W-1:0]  in_phy  [NSRC];
  logic [TAG_W-1:0]  in_idx  [NSRC];

  assign in_vld     = {ld_vld, mult_vld, alu2_vld, alu1_vld};
  assign in_wrt     = {ld_wrt, mult_wrt, alu2_wrt, alu1_wrt};
  assign in_data[0] = alu1_data;
  assign in_data[1] = alu2_data;
  assign in_data[2] = mult_data;
  assign in_data[3] = ld_data;
  assign in_phy[0]  = alu1_phy;
  assign in_phy[1]  = alu2_phy;
  assign in_phy[2]  = mult_phy;
  assign in_phy[3]  = ld_phy;
  assign in_idx[0]  = alu1_idx;
  assign in_idx[1]  = alu2_idx;
  assign in_idx[2]  = mult_idx;
  assign in_idx[3]  = ld_idx;

  // Holding entries
  logic [NSRC-1:0]   occ_q, occ_d, wrt_q, wrt_d;
  logic [DATA_W-1:0] data_q [NSRC];
  logic [DATA_W-1:0] data_d [NSRC];
  logic [TAG_W-1:0]  phy_q  [NSRC];
  logic [TAG_W-1:0]  phy_d  [NSRC];
  logic [TAG_W-1:0]  idx_q  [NSRC];
  logic [TAG_W-1:0]  idx_d  [NSRC];
  logic [1:0]        rr_q, rr_d;

  // Registered port outputs, indexed by port number
  logic [1:0]        wp_en_q, wp_en_d, cmpl_vld_q, cmpl_vld_d;
  logic [TAG_W-1:0]  wp_addr_q  [2];
  logic [TAG_W-1:0]  wp_addr_d  [2];
  logic [DATA_W-1:0] wp_data_q  [2];
  logic [DATA_W-1:0] wp_data_d  [2];
  logic [TAG_W-1:0]  cmpl_idx_q [2];
  logic [TAG_W-1:0]  cmpl_idx_d [2];

  logic [1:0]        g_vld;
  logic [1:0]        g_sel [2];
  logic [1:0]        scan;
  logic [NSRC-1:0]   gnt_mask;
  logic [2:0]        occ_cnt;

  // Stall depends only on held state so there is no input-to-stall path
  assign occ_cnt   = 3'(occ_q[0]) + 3'(occ_q[1]) + 3'(occ_q[2]) + 3'(occ_q[3]);
  assign stall_out = (occ_cnt > 3'd2);

  // Rotating scan picks up to two occupied entries; pointer follows the last pick
  always_comb begin
    g_vld    = '0;
    g_sel[0] = '0;
    g_sel[1] = '0;
    rr_d     = rr_q;
    scan     = '0;
`ifdef WB_LD_PRIORITY_EN
    if (occ_q[LD]) begin
      g_vld[0] = 1'b1;
      g_sel[0] = LD;
    end
`endif
    for (int k = 0; k < NSRC; k++) begin
      scan = rr_q + 2'(k);
`ifdef WB_LD_PRIORITY_EN
      if (occ_q[scan] && (scan != LD)) begin
`else
      if (occ_q[scan]) begin
`endif
        if (!g_vld[0]) begin
          g_vld[0] = 1'b1;
          g_sel[0] = scan;
          rr_d     = scan + 2'd1;
        end else if (!g_vld[1]) begin
          g_vld[1] = 1'b1;
          g_sel[1] = scan;
          rr_d     = scan + 2'd1;
        end
      end
    end
  end

  // Entry next state: load everything when not stalled, else retire granted ones
  always_comb begin
    gnt_mask = '0;
    for (int p = 0; p < 2; p++) begin
      if (g_vld[p]) gnt_mask[g_sel[p]] = 1'b1;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (!stall_out) begin
        occ_d[i]  = in_vld[i];
        wrt_d[i]  = in_wrt[i];
        data_d[i] = in_data[i];
        phy_d[i]  = in_phy[i];
        idx_d[i]  = in_idx[i];
      end else begin
        occ_d[i]  = occ_q[i] & ~gnt_mask[i];
        wrt_d[i]  = wrt_q[i];
        data_d[i] = data_q[i];
        phy_d[i]  = phy_q[i];
        idx_d[i]  = idx_q[i];
      end
    end
  end

  // Port outputs carry the granted entry, or all zeros when the port is idle
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wp_en_d[p]    = g_vld[p] & wrt_q[g_sel[p]];
      cmpl_vld_d[p] = g_vld[p];
      wp_addr_d[p]  = g_vld[p] ? phy_q[g_sel[p]]  : '0;
      wp_data_d[p]  = g_vld[p] ? data_q[g_sel[p]] : '0;
      cmpl_idx_d[p] = g_vld[p] ? idx_q[g_sel[p]]  : '0;
    end
  end

  // State and output registers; reset discards any pending entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= '0;
      wrt_q      <= '0;
      rr_q       <= '0;
      wp_en_q    <= '0;
      cmpl_vld_q <= '0;
      for (int i = 0; i < NSRC; i++) begin
        data_q[i] <= '0;
        phy_q[i]  <= '0;
        idx_q[i]  <= '0;
      end
      for (int p = 0; p < 2; p++) begin
        wp_addr_q[p]  <= '0;
        wp_data_q[p]  <= '0;
        cmpl_idx_q[p] <= '0;
      end
    end else begin
      occ_q      <= occ_d;
      wrt_q      <= wrt_d;
      rr_q       <= rr_d;
      wp_en_q    <= wp_en_d;
      cmpl_vld_q <= cmpl_vld_d;
      for (int i = 0; i < NSRC; i++) begin
        data_q[i] <= data_d[i];
        phy_q[i]  <= phy_d[i];
        idx_q[i]  <= idx_d[i];
      end
      for (int p = 0; p < 2; p++) begin
        wp_addr_q[p]  <= wp_addr_d[p];
        wp_data_q[p]  <= wp_data_d[p];
        cmpl_idx_q[p] <= cmpl_idx_d[p];
      end
    end
  end

  assign wp_en_0    = wp_en_q[0];
  assign wp_addr_0  = wp_addr_q[0];
  assign wp_data_0  = wp_data_q[0];
  assign cmpl_vld_0 = cmpl_vld_q[0];
  assign cmpl_idx_0 = cmpl_idx_q[0];
  assign wp_en_1    = wp_en_q[1];
  assign wp_addr_1  = wp_addr_q[1];
  assign wp_data_1  = wp_data_q[1];
  assign cmpl_vld_1 = cmpl_vld_q[1];
  assign cmpl_idx_1 = cmpl_idx_q[1];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model of wb_port_arbiter.
// Honours WB_LD_PRIORITY_EN when the bundle is built with it.
module tb_wb_port_arbiter;
  localparam int DW = 16;
  localparam int TW = 6;
`ifdef WB_LD_PRIORITY_EN
  localparam bit PRI = 1'b1;
`else
  localparam bit PRI = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    vld_i, wrt_i;
  logic [DW-1:0] data_i [4];
  logic [TW-1:0] phy_i  [4];
  logic [TW-1:0] idx_i  [4];

  logic          wp_en_0, wp_en_1, cmpl_vld_0, cmpl_vld_1, stall_out;
  logic [TW-1:0] wp_addr_0, wp_addr_1, cmpl_idx_0, cmpl_idx_1;
  logic [DW-1:0] wp_data_0, wp_data_1;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu1_vld(vld_i[0]), .alu1_wrt(wrt_i[0]), .alu1_data(data_i[0]), .alu1_phy(phy_i[0]), .alu1_idx(idx_i[0]),
    .alu2_vld(vld_i[1]), .alu2_wrt(wrt_i[1]), .alu2_data(data_i[1]), .alu2_phy(phy_i[1]), .alu2_idx(idx_i[1]),
    .mult_vld(vld_i[2]), .mult_wrt(wrt_i[2]), .mult_data(data_i[2]), .mult_phy(phy_i[2]), .mult_idx(idx_i[2]),
    .ld_vld(vld_i[3]),   .ld_wrt(wrt_i[3]),   .ld_data(data_i[3]),   .ld_phy(phy_i[3]),   .ld_idx(idx_i[3]),
    .wp_en_0(wp_en_0), .wp_addr_0(wp_addr_0), .wp_data_0(wp_data_0),
    .cmpl_vld_0(cmpl_vld_0), .cmpl_idx_0(cmpl_idx_0),
    .wp_en_1(wp_en_1), .wp_addr_1(wp_addr_1), .wp_data_1(wp_data_1),
    .cmpl_vld_1(cmpl_vld_1), .cmpl_idx_1(cmpl_idx_1),
    .stall_out(stall_out)
  );

  typedef struct packed {
    logic          en;
    logic [TW-1:0] addr;
    logic [DW-1:0] data;
    logic          cv;
    logic [TW-1:0] idx;
  } port_t;

  typedef struct packed {
    logic  stall;
    port_t p0;
    port_t p1;
  } out_t;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] wrt;
    logic       stall;
    logic       v0;
    int         r0;
    int         s0;
    logic       v1;
    int         r1;
    int         s1;
  } vec_t;

  typedef struct {
    logic          occ;
    logic          wrt;
    logic [DW-1:0] data;
    logic [TW-1:0] phy;
    logic [TW-1:0] idx;
  } ent_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  ent_t  m_ent [4];
  int    m_rr;
  port_t m_p0, m_p1;
  vec_t  tbl [11];

  function automatic port_t mk_port(logic v, logic w, logic [TW-1:0] a, logic [DW-1:0] d, logic [TW-1:0] i);
    port_t p;
    p = '0;
    if (v) begin
      p.en = w; p.addr = a; p.data = d; p.cv = 1'b1; p.idx = i;
    end
    return p;
  endfunction

  // Row-derived operand values let an expected idx identify which row was captured
  function automatic logic [TW-1:0] tidx(int r, int s);
    return 6'(r * 4 + s);
  endfunction
  function automatic logic [TW-1:0] tphy(int r, int s);
    return tidx(r, s) ^ 6'h2A;
  endfunction
  function automatic logic [DW-1:0] tdata(int r, int s);
    return {10'h2B5, tidx(r, s)};
  endfunction
  function automatic port_t exp_src(int r, int s, logic w);
    return mk_port(1'b1, w, tphy(r, s), tdata(r, s), tidx(r, s));
  endfunction

  function automatic vec_t mkv(logic [3:0] v, logic [3:0] w, logic st,
                               logic v0, int r0, int s0, logic v1, int r1, int s1);
    vec_t t;
    t.vld = v; t.wrt = w; t.stall = st;
    t.v0 = v0; t.r0 = r0; t.s0 = s0; t.v1 = v1; t.r1 = r1; t.s1 = s1;
    return t;
  endfunction

  task automatic set_row(int r, logic [3:0] v, logic [3:0] w);
    vld_i = v;
    wrt_i = w;
    for (int s = 0; s < 4; s++) begin
      idx_i[s]  = tidx(r, s);
      phy_i[s]  = tphy(r, s);
      data_i[s] = tdata(r, s);
    end
  endtask

  // Reference model: collect occupied entries in priority order, serve the first two
  task automatic model_reset();
    for (int s = 0; s < 4; s++) m_ent[s] = '{1'b0, 1'b0, '0, '0, '0};
    m_rr = 0;
    m_p0 = '0;
    m_p1 = '0;
  endtask

  task automatic model_edge();
    int    sel[$];
    int    cnt;
    int    s;
    port_t np[2];
    cnt = 0;
    for (int e = 0; e < 4; e++) if (m_ent[e].occ) cnt++;
    if (PRI && m_ent[3].occ) sel.push_back(3);
    for (int k = 0; k < 4; k++) begin
      s = (m_rr + k) % 4;
      if (m_ent[s].occ && !(PRI && s == 3)) sel.push_back(s);
    end
    while (sel.size() > 2) void'(sel.pop_back());
    np[0] = '0;
    np[1] = '0;
    foreach (sel[j]) begin
      np[j] = mk_port(1'b1, m_ent[sel[j]].wrt, m_ent[sel[j]].phy, m_ent[sel[j]].data, m_ent[sel[j]].idx);
      if (!(PRI && sel[j] == 3)) m_rr = (sel[j] + 1) % 4;
    end
    if (cnt <= 2) begin
      for (int e = 0; e < 4; e++) m_ent[e] = '{vld_i[e], wrt_i[e], data_i[e], phy_i[e], idx_i[e]};
    end else begin
      foreach (sel[j]) m_ent[sel[j]].occ = 1'b0;
    end
    m_p0 = np[0];
    m_p1 = np[1];
  endtask

  function automatic out_t model_exp();
    out_t e;
    int   cnt;
    cnt = 0;
    for (int k = 0; k < 4; k++) if (m_ent[k].occ) cnt++;
    e.stall = (cnt > 2);
    e.p0 = m_p0;
    e.p1 = m_p1;
    return e;
  endfunction

  function automatic out_t get_act();
    out_t a;
    a.stall = stall_out;
    a.p0 = {wp_en_0, wp_addr_0, wp_data_0, cmpl_vld_0, cmpl_idx_0};
    a.p1 = {wp_en_1, wp_addr_1, wp_data_1, cmpl_vld_1, cmpl_idx_1};
    return a;
  endfunction

  task automatic chk(string nm, out_t exp);
    out_t act;
    act = get_act();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got stall=%0b p0=%h p1=%h, expected stall=%0b p0=%h p1=%h",
               nm, act.stall, act.p0, act.p1, exp.stall, exp.p0, exp.p1);
    end else begin
      $display("ok   %s: stall=%0b p0=%h p1=%h", nm, act.stall, act.p0, act.p1);
    end
  endtask

  // One clock: model consumes current inputs, then sample 1 ns after the edge
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vld_i = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    out_t e;
    vld_i = '0;
    wrt_i = '0;
    for (int s = 0; s < 4; s++) begin
      data_i[s] = '0; phy_i[s] = '0; idx_i[s] = '0;
    end

    // vld, wrt, stall after edge, port0 (valid,row,src), port1 (valid,row,src)
    tbl[0]  = mkv(4'b0101, 4'b1111, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    tbl[1]  = mkv(4'b0000, 4'b1111, 1'b0, 1'b1, 0, 0, 1'b1, 0, 2);
    tbl[2]  = mkv(4'b1111, 4'b1111, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    tbl[3]  = mkv(4'b1111, 4'b1111, 1'b0, 1'b1, 2, 3, 1'b1, 2, 0);
    tbl[4]  = mkv(4'b0010, 4'b1111, 1'b0, 1'b1, 2, 1, 1'b1, 2, 2);
    tbl[5]  = mkv(4'b0000, 4'b1111, 1'b0, 1'b1, 4, 1, 1'b0, 0, 0);
    tbl[6]  = mkv(4'b1011, 4'b0111, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    tbl[7]  = mkv(4'b0100, 4'b1111, 1'b0, 1'b1, 6, 3, 1'b1, 6, 0);
    tbl[8]  = mkv(4'b0100, 4'b1111, 1'b0, 1'b1, 6, 1, 1'b0, 0, 0);
    tbl[9]  = mkv(4'b0000, 4'b1111, 1'b0, 1'b1, 8, 2, 1'b0, 0, 0);
    tbl[10] = mkv(4'b0000, 4'b1111, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);

    // Reset with every source valid, then four-way contention from rr=0
    set_row(12, 4'hF, 4'hF);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", '0);
    rst_n = 1'b1;
    step();
    e = '0; e.stall = 1'b1;
    chk("rst_release_e1", e);
    set_row(13, 4'hF, 4'hF);
    step();
    e = '0;
    e.p0 = PRI ? exp_src(12, 3, 1'b1) : exp_src(12, 0, 1'b1);
    e.p1 = PRI ? exp_src(12, 0, 1'b1) : exp_src(12, 1, 1'b1);
    chk("four_first", e);
    set_row(13, 4'h0, 4'hF);
    step();
    e.p0 = PRI ? exp_src(12, 1, 1'b1) : exp_src(12, 2, 1'b1);
    e.p1 = PRI ? exp_src(12, 2, 1'b1) : exp_src(12, 3, 1'b1);
    chk("four_second", e);
    step();
    chk("stall_inputs_dropped", '0);

    // Pointer probe: alu2 and ld together
    set_row(14, 4'b1010, 4'hF);
    step();
    chk("rr_probe_capture", '0);
    set_row(14, 4'b0000, 4'hF);
    step();
    e = '0;
    e.p0 = PRI ? exp_src(14, 3, 1'b1) : exp_src(14, 1, 1'b1);
    e.p1 = PRI ? exp_src(14, 1, 1'b1) : exp_src(14, 3, 1'b1);
    chk("rr_probe", e);

    // Single source with fixed operands
    vld_i = 4'b0001; wrt_i = 4'hF;
    phy_i[0] = 6'd5; data_i[0] = 16'hBEEF; idx_i[0] = 6'd9;
    step();
    chk("single_t1", '0);
    vld_i = '0;
    step();
    e = '0; e.p0 = mk_port(1'b1, 1'b1, 6'd5, 16'hBEEF, 6'd9);
    chk("single_t2", e);

    // Store: completion without register write
    vld_i = 4'b1000; wrt_i = 4'b0111;
    phy_i[3] = 6'd7; data_i[3] = 16'h1234; idx_i[3] = 6'd33;
    step();
    chk("store_t1", '0);
    vld_i = '0;
    step();
    e = '0; e.p0 = mk_port(1'b1, 1'b0, 6'd7, 16'h1234, 6'd33);
    chk("store_cmpl", e);

    // Asynchronous reset while three entries are pending
    set_row(15, 4'b0111, 4'hF);
    step();
    e = '0; e.stall = 1'b1;
    chk("pre_reset_stall", e);
    vld_i = '0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset", '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("post_reset_1", '0);
    step();
    chk("post_reset_2", '0);

    // Four valid with rr=1
    set_row(13, 4'b0001, 4'hF);
    step();
    chk("prio_setup_t1", '0);
    set_row(14, 4'hF, 4'hF);
    step();
    e = '0; e.stall = 1'b1; e.p0 = exp_src(13, 0, 1'b1);
    chk("prio_setup_t2", e);
    set_row(14, 4'h0, 4'hF);
    step();
    e = '0;
    e.p0 = PRI ? exp_src(14, 3, 1'b1) : exp_src(14, 1, 1'b1);
    e.p1 = PRI ? exp_src(14, 1, 1'b1) : exp_src(14, 2, 1'b1);
    chk("prio_first", e);
    step();
    e.p0 = PRI ? exp_src(14, 2, 1'b1) : exp_src(14, 3, 1'b1);
    e.p1 = exp_src(14, 0, 1'b1);
    chk("prio_second", e);

    // Vector table from a fresh reset
    do_reset();
    for (int r = 0; r < 11; r++) begin
      set_row(r, tbl[r].vld, tbl[r].wrt);
      step();
      e = '0;
      e.stall = tbl[r].stall;
      if (tbl[r].v0) e.p0 = exp_src(tbl[r].r0, tbl[r].s0, tbl[tbl[r].r0].wrt[tbl[r].s0]);
      if (tbl[r].v1) e.p1 = exp_src(tbl[r].r1, tbl[r].s1, tbl[tbl[r].r1].wrt[tbl[r].s1]);
      chk($sformatf("table_row%0d", r), e);
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      vld_i = 4'($urandom_range(0, 15));
      wrt_i = 4'($urandom_range(0, 15));
      for (int s = 0; s < 4; s++) begin
        data_i[s] = 16'($urandom);
        phy_i[s]  = 6'($urandom);
        idx_i[s]  = 6'($urandom);
      end
      step();
      chk($sformatf("rand_%0d", c), model_exp());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Writeback port arbiter that sits after the EX/WB pipeline register. It merges four result sources (alu1, alu2, mult, ld) onto the two physical-register-file write ports and the two ROB completion ports. Each source has a one-entry holding buffer, and contention is resolved by a rotating-priority pointer. When more than two results are pending, the block raises a stall back to the EX/WB register.

## Interface
Parameters:
- DATA_W, 16, result data width
- TAG_W, 6, physical register address and ROB index width

Ports (s ∈ {alu1, alu2, mult, ld}; p ∈ {0, 1}):
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_vld  in  1  source s presents a completed instruction
- s_wrt  in  1  source s result writes the register file
- s_data  in  DATA_W  result value
- s_phy  in  TAG_W  destination physical register
- s_idx  in  TAG_W  ROB index of the instruction
- wp_en_p  out  1  register-file write enable, port p
- wp_addr_p  out  TAG_W  register-file write address, port p
- wp_data_p  out  DATA_W  register-file write data, port p
- cmpl_vld_p  out  1  ROB completion valid, port p
- cmpl_idx_p  out  TAG_W  ROB completion index, port p
- stall_out  out  1  hold request to the EX/WB register

## Operation
- Each source has a holding entry with fields occ, wrt, data, phy, idx.
- occ_cnt is the number of occupied entries.
- stall_out = (occ_cnt > 2). It is combinational from entry state only, with no path from the inputs.
- Grant each cycle:
  - Scan the four entries in order rr, rr+1, rr+2, rr+3 (mod 4; order alu1=0, alu2=1, mult=2, ld=3).
  - The first occupied entry goes to port 0 and the second to port 1. At most two grants per cycle.
- Granted entries clear occ at the next edge. Non-granted occupied entries hold their contents.
- Capture rule:
  - When stall_out=0, every occupied entry is granted, so all entries are free. Each entry loads {s_vld, s_wrt, s_data, s_phy, s_idx} at the edge.
  - When stall_out=1, inputs are ignored. The upstream register is holding the same values and re-presents them later.
- rr update: when a grant occurs, rr ← (index of last granted entry + 1) mod 4. With no grants, rr holds.
- Output register update at the edge:
  - cmpl_vld_p ← grant on p.
  - wp_en_p ← grant on p AND the entry's wrt.
  - Addr, data and idx come from the granted entry.
  - When there is no grant on p, all port p outputs are 0.
- An entry with s_wrt=0 (store, branch) still consumes a completion slot. Its wp_en stays 0.
- Two ports never receive the same entry. A same-phy collision between ports is the upstream renamer's error; no check is made.

## Timing
- Reset (asynchronous): all occ=0, rr=0, stall_out=0, and every wp_*/cmpl_* output is 0. Asserting reset mid-operation discards pending entries.
- Uncontended latency: s_vld high in cycle t → entry occupied in t+1 → wp_en_p/cmpl_vld_p high in t+2.
- With 3 occupied entries: stall_out is high for 1 cycle. Two entries retire in that cycle and one in the next, with new capture allowed in that next cycle.
- With 4 occupied entries: stall_out is high for 1 cycle (4→2), then low. All four retire within 2 cycles.
- A wrap-around scan treats entry 3 → 0 as consecutive in the order.

## Configuration
- WB_LD_PRIORITY_EN defined:
  - An occupied ld entry is always granted on port 0, regardless of rr.
  - The remaining port goes to the first occupied non-ld entry in rr order.
  - rr update considers only non-ld grants.
- WB_LD_PRIORITY_EN undefined: ld participates in plain rotation as entry 3.

## Test plan
- Reset: drive rst_n=0 with all s_vld=1 → all outputs 0 and stall_out=0. Release rst_n → first grants appear 2 cycles later.
- Single source: alu1_vld=1, phy=6'd5, data=16'hBEEF, idx=6'd9 at t → wp_en_0=1, wp_addr_0=5, wp_data_0=BEEF, cmpl_idx_0=9 at t+2. Port 1 stays idle.
- Two sources: alu1 and mult valid together with rr=0 → alu1 on port 0 and mult on port 1 in the same cycle, and stall_out never rises.
- Four sources from rr=0: stall_out=1 for one cycle with alu1/alu2 granted, then mult/ld in the next cycle. After that rr=0. Inputs presented during the stall cycle are not captured.
- Store completion: ld_vld=1, ld_wrt=0 → cmpl_vld=1, wp_en=0.
- Priority macro: with all four valid and rr=1, WB_LD_PRIORITY_EN defined → first cycle grants ld on port 0 and alu2 on port 1. Undefined → first cycle grants alu2 on port 0 and mult on port 1.
